// File: rtl/vram_pkg.sv
// Shared timing constants, FSM state type and address helper for the VRAM arbiter.
package vram_pkg;

  localparam int H_TOTAL        = 800;
  localparam int V_ACTIVE       = 480;
  localparam int V_TOTAL        = 525;
  localparam int CELL_SHIFT     = 3;
  localparam int WORDS_PER_LINE = 10;
  localparam int FETCH_LEAD     = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_DISP,
    ARB_HOST
  } arb_state_t;

  // Cell row * WORDS_PER_LINE as shift-and-add, so no multiplier is built.
  function automatic logic [10:0] times_ten(input logic [6:0] v);
    return {1'b0, v, 3'b000} + {3'b000, v, 1'b0};
  endfunction

endpackage

// File: rtl/vram_fetch_sched.sv
// Combinational display-fetch schedule: which beam positions own the VRAM,
// which word they fetch, and when the prefetched word becomes the shown word.
module vram_fetch_sched
  import vram_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic [9:0]        row_counter,
  input  logic [9:0]        col_counter,
  output logic              fetch_slot,
  output logic [ADDR_W-1:0] fetch_addr,
  output logic              disp_load
);

  logic [10:0] col_lead;
  logic        slot_mid;
  logic        slot_w0;
  logic [9:0]  y;
  logic [3:0]  w;
  logic [10:0] addr_sum;

  always_comb begin
    col_lead = {1'b0, col_counter} + 11'(FETCH_LEAD);
    // Words 1..9 are fetched FETCH_LEAD columns before their 64-column span.
    slot_mid = (col_lead[5:0] == 6'd0) && (col_lead[10:6] >= 5'd1) &&
               (col_lead[10:6] <= 5'(WORDS_PER_LINE - 1));
    slot_w0  = (col_counter == 10'(H_TOTAL - FETCH_LEAD));

    // Word 0 belongs to the next line, wrapping the last line to row 0.
    y = row_counter;
    if (slot_w0)
      y = (row_counter == 10'(V_TOTAL - 1)) ? 10'd0 : row_counter + 10'd1;
    w = slot_w0 ? 4'd0 : col_lead[9:6];

    fetch_slot = (slot_mid || slot_w0) && (y < 10'(V_ACTIVE));
    addr_sum   = times_ten(7'(y >> CELL_SHIFT)) + {7'd0, w};
    fetch_addr = ADDR_W'(addr_sum);

    disp_load = (col_counter == 10'(H_TOTAL - 1)) ||
                ((col_counter[5:0] == 6'd63) &&
                 (col_counter[9:6] <= 4'(WORDS_PER_LINE - 2)));
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM shared between display refill (fixed slots, always wins) and
// a host req/ack port; serialises 1-bpp cell words to pixels.
// Build option: VRAM_ARB_HOST_READ_EN enables host reads (else every host op writes).
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        row_counter,
  input  logic [9:0]        col_counter,
  input  logic              screen_inactive,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pixel
);

  logic              fetch_slot;
  logic              disp_load;
  logic [ADDR_W-1:0] fetch_addr;
  arb_state_t        state_q, state_d;
  logic              ack_q;
  logic              host_wr;
  logic [DATA_W-1:0] prefetch_q;
  logic [DATA_W-1:0] disp_word_q;

  vram_fetch_sched #(.ADDR_W(ADDR_W)) u_sched (
    .row_counter (row_counter),
    .col_counter (col_counter),
    .fetch_slot  (fetch_slot),
    .fetch_addr  (fetch_addr),
    .disp_load   (disp_load)
  );

`ifdef VRAM_ARB_HOST_READ_EN
  assign host_wr = host_we;
`else
  logic host_we_unused;
  assign host_we_unused = host_we;
  assign host_wr        = 1'b1;
`endif

  // Outputs are held at zero while reset is asserted, even though it is synchronous.
  always_comb begin
    state_d   = ARB_IDLE;
    host_ack  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst_n) begin
      if (fetch_slot) begin
        state_d  = ARB_DISP;
        mem_en   = 1'b1;
        mem_addr = fetch_addr;
      end else if (host_req && !ack_q) begin
        state_d   = ARB_HOST;
        host_ack  = 1'b1;
        mem_en    = 1'b1;
        mem_we    = host_wr;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      ack_q       <= 1'b0;
      prefetch_q  <= '0;
      disp_word_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= host_ack;
      if (state_q == ARB_DISP) prefetch_q <= mem_rdata;
      if (disp_load)           disp_word_q <= prefetch_q;
    end
  end

`ifdef VRAM_ARB_HOST_READ_EN
  logic rd_q;

  always_ff @(posedge clk) begin
    if (!rst_n) rd_q <= 1'b0;
    else        rd_q <= host_ack && !host_we;
  end

  assign host_rvalid = rst_n && (state_q == ARB_HOST) && rd_q;
  assign host_rdata  = host_rvalid ? mem_rdata : '0;
`else
  assign host_rvalid = 1'b0;
  assign host_rdata  = '0;
`endif

  // ~col[5:3] == 7 - col[5:3]: bit 7 is the leftmost cell of the word.
  assign pixel = rst_n && !screen_inactive && disp_word_q[~col_counter[5:3]];

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: drives beam counters directly, models
// the VRAM, and scoreboards host read data.
module tb_vram_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [9:0]        row_counter = '0;
  logic [9:0]        col_counter = '0;
  logic              screen_inactive = 1'b0;
  logic              host_req = 1'b0;
  logic              host_we = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [DATA_W-1:0] host_wdata = '0;
  logic              host_ack;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              pixel;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .row_counter(row_counter), .col_counter(col_counter),
    .screen_inactive(screen_inactive), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pixel(pixel)
  );

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;
  bit req_v  = 0;
  bit rst_v  = 0;
  bit pix_chk = 0;

  logic [7:0] vram   [1024];
  logic [7:0] shadow [1024];

  typedef struct { logic [7:0] data; int due; } rd_exp_t;
  rd_exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // VRAM model: request sampled mid-cycle, applied at the closing edge.
  logic       p_en = 1'b0, p_we = 1'b0;
  logic [9:0] p_addr = '0;
  logic [7:0] p_wdata = '0;
  always @(negedge clk) begin
    p_en <= mem_en; p_we <= mem_we; p_addr <= mem_addr; p_wdata <= mem_wdata;
  end
  always @(posedge clk) begin
    if (p_en) begin
      if (p_we) vram[p_addr] <= p_wdata;
      else      mem_rdata <= vram[p_addr];
    end
  end

  // Read-data scoreboard.
  rd_exp_t e;
  always @(negedge clk) begin
    if (host_rvalid) begin
      if (sb.size() == 0) chk("rvalid_spurious", 32'(host_rvalid), 32'd0);
      else begin
        e = sb.pop_front();
        chk("rdata", 32'(host_rdata), 32'(e.data));
        chk("rvalid_latency", 32'(cyc_n), 32'(e.due));
      end
    end
  end

  function automatic bit exp_slot(input int r, input int c, output int addr);
    int y, w;
    addr = 0;
    if (c == 796) begin y = (r == 524) ? 0 : r + 1; w = 0; end
    else if (c >= 60 && c <= 572 && (c + 4) % 64 == 0) begin y = r; w = (c + 4) / 64; end
    else return 0;
    if (y >= 480) return 0;
    addr = (y / 8) * 10 + w;
    return 1;
  endfunction

  function automatic logic exp_pixel(input int r, input int c);
    logic [7:0] wd;
    if (r >= 480 || c >= 640) return 1'b0;
    wd = shadow[(r / 8) * 10 + c / 64];
    return wd[7 - (c / 8) % 8];
  endfunction

  task automatic drive(input int r, input int c);
    int a;
    @(posedge clk); #1;
    cyc_n++;
    rst_n           = rst_v;
    row_counter     = 10'(r);
    col_counter     = 10'(c);
    screen_inactive = (r >= 480 || c >= 640);
    host_req        = req_v;
    @(negedge clk);
    if (rst_n) begin
      if (exp_slot(r, c, a)) begin
        chk($sformatf("slot_en r%0d c%0d", r, c), 32'(mem_en), 32'd1);
        chk($sformatf("slot_we r%0d c%0d", r, c), 32'(mem_we), 32'd0);
        chk($sformatf("slot_addr r%0d c%0d", r, c), 32'(mem_addr), 32'(a));
        chk($sformatf("slot_ack r%0d c%0d", r, c), 32'(host_ack), 32'd0);
      end else if (!req_v) begin
        chk($sformatf("idle_en r%0d c%0d", r, c), 32'(mem_en), 32'd0);
      end
      if (pix_chk || screen_inactive)
        chk($sformatf("pixel r%0d c%0d", r, c), 32'(pixel), 32'(exp_pixel(r, c)));
    end
  endtask

  task automatic run_line(input int r, input int c0, input int c1);
    for (int c = c0; c <= c1; c++) drive(r, c);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pixel"},  32'(pixel),       32'd0);
    chk({tag, "_ack"},    32'(host_ack),    32'd0);
    chk({tag, "_rvalid"}, 32'(host_rvalid), 32'd0);
    chk({tag, "_rdata"},  32'(host_rdata),  32'd0);
    chk({tag, "_en"},     32'(mem_en),      32'd0);
    chk({tag, "_we"},     32'(mem_we),      32'd0);
    chk({tag, "_addr"},   32'(mem_addr),    32'd0);
    chk({tag, "_wdata"},  32'(mem_wdata),   32'd0);
  endtask

  task automatic host_op(input int r, input int c, input bit we, input int addr,
                         input logic [7:0] wd, input int exp_wait, output int c_next);
    bit got = 0;
    bit eff_we;
`ifdef VRAM_ARB_HOST_READ_EN
    eff_we = we;
`else
    eff_we = 1'b1;
`endif
    host_we = we; host_addr = 10'(addr); host_wdata = wd; req_v = 1;
    c_next = c + 4;
    for (int i = 0; i < 4 && !got; i++) begin
      drive(r, c + i);
      if (host_ack) begin
        got = 1;
        chk("ack_wait", 32'(i), 32'(exp_wait));
        chk("grant_en", 32'(mem_en), 32'd1);
        chk("grant_we", 32'(mem_we), 32'(eff_we));
        chk("grant_addr", 32'(mem_addr), 32'(addr));
        if (eff_we) begin
          chk("grant_wdata", 32'(mem_wdata), 32'(wd));
          shadow[addr] = wd;
        end else begin
          sb.push_back('{shadow[addr], cyc_n + 1});
        end
        req_v = 0;
        c_next = c + i + 1;
      end
    end
    if (!got) begin
      chk("ack_timeout", 32'd0, 32'd1);
      req_v = 0;
    end
  endtask

  int cn;
  initial begin
    for (int i = 0; i < 1024; i++) begin vram[i] = 8'h00; shadow[i] = 8'h00; end

    // Reset held across a fetch slot: everything must read zero.
    rst_v = 0;
    drive(10, 59); check_zero("rst0");
    drive(10, 60); check_zero("rst1");
    drive(10, 61); check_zero("rst2");
    rst_v = 1;
    drive(10, 62);

    // Free-cycle write, then a write colliding with the row-10 word-1 fetch.
    host_op(0, 100, 1, 0, 8'h80, 0, cn);
    drive(0, cn);
    host_op(10, 60, 1, 599, 8'h01, 1, cn);
    drive(10, cn);

    // Top-left cell lit on rows 0..7.
    run_line(524, 790, 799);
    pix_chk = 1;
    for (int r = 0; r < 8; r++) run_line(r, 0, 799);
    pix_chk = 0;

    // Bottom-right cell lit on rows 472..479.
    run_line(471, 790, 799);
    pix_chk = 1;
    for (int r = 472; r < 480; r++) run_line(r, 0, 799);
    pix_chk = 0;

    // Vertical blanking: no fetches, dark; row 524 col 796 prefetches row 0.
    for (int r = 480; r < 484; r++) run_line(r, 0, 799);
    run_line(523, 790, 799);
    run_line(524, 0, 799);

    // Held request: acks at most every other cycle.
    host_we = 1; host_addr = 10'd700; host_wdata = 8'h11; req_v = 1;
    drive(300, 300); chk("hold_ack0", 32'(host_ack), 32'd1);
    drive(300, 301); chk("hold_ack1", 32'(host_ack), 32'd0);
    drive(300, 302); chk("hold_ack2", 32'(host_ack), 32'd1);
    drive(300, 303); chk("hold_ack3", 32'(host_ack), 32'd0);
    req_v = 0;
    shadow[700] = 8'h11;
    drive(300, 304);

    // Write then read back the last displayed word.
    host_op(200, 200, 1, 599, 8'h3C, 0, cn);
    drive(200, cn);
    host_op(200, cn + 1, 0, 599, 8'hA5, 0, cn);
    drive(200, cn);
    drive(200, cn + 1);
    drive(200, cn + 2);

    // Mid-frame reset with a request held through it.
    drive(20, 122);
    host_we = 1; host_addr = 10'd650; host_wdata = 8'h22;
    rst_v = 0; req_v = 1;
    drive(20, 123); check_zero("mrst0");
    drive(20, 124); check_zero("mrst1");
    rst_v = 1;
    drive(20, 125);
    chk("post_rst_ack", 32'(host_ack), 32'd1);
    chk("post_rst_addr", 32'(mem_addr), 32'd650);
    chk("post_rst_we", 32'(mem_we), 32'd1);
    req_v = 0;
    shadow[650] = 8'h22;
    drive(20, 126);
    drive(20, 127);

    chk("sb_drain", 32'(sb.size()), 32'd0);
    chk("vram_650", 32'(vram[650]), 32'(shadow[650]));
    chk("vram_599", 32'(vram[599]), 32'(shadow[599]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
